// File: rtl/aes_pkg.sv
// Shared types, sizing constants and GF(2^8) helpers for the iterative AES engine.
package aes_pkg;

  localparam int BLOCK_W  = 128;
  localparam int RK_IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_state_e;

  function automatic int NR_OF(input int nk);
    return nk + 6;
  endfunction

  function automatic bit nk_is_legal(input int nk);
    return (nk == 4) || (nk == 6) || (nk == 8);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // S-box as multiplicative inverse (x^254, zero maps to zero) followed by the affine map.
  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    p   = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_round_datapath.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_datapath
  import aes_pkg::*;
(
  input  logic [0:BLOCK_W-1] i_state,
  input  logic [0:BLOCK_W-1] i_key,
  input  logic               i_final,
  output logic [0:BLOCK_W-1] o_state
);

  logic [7:0] w_sb [16];
  logic [7:0] w_sr [16];
  logic [7:0] w_mc [16];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_sb[i] = sub_byte(i_state[8*i +: 8]);
    end
  end

  // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sr[4*c + r] = w_sb[4*((c + r) % 4) + r];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_mc[4*c + 0] = xtime(w_sr[4*c]) ^ xtime(w_sr[4*c+1]) ^ w_sr[4*c+1] ^
                      w_sr[4*c+2] ^ w_sr[4*c+3];
      w_mc[4*c + 1] = w_sr[4*c] ^ xtime(w_sr[4*c+1]) ^ xtime(w_sr[4*c+2]) ^
                      w_sr[4*c+2] ^ w_sr[4*c+3];
      w_mc[4*c + 2] = w_sr[4*c] ^ w_sr[4*c+1] ^ xtime(w_sr[4*c+2]) ^
                      xtime(w_sr[4*c+3]) ^ w_sr[4*c+3];
      w_mc[4*c + 3] = xtime(w_sr[4*c]) ^ w_sr[4*c] ^ w_sr[4*c+1] ^
                      w_sr[4*c+2] ^ xtime(w_sr[4*c+3]);
    end
  end

  always_comb begin
    o_state = '0;
    for (int i = 0; i < 16; i++) begin
      o_state[8*i +: 8] = (i_final ? w_sr[i] : w_mc[i]) ^ i_key[8*i +: 8];
    end
  end

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES encryptor: one round per clock on a shared round datapath,
// round keys fetched by index from an external key store.
//
// state    | meaning
// ST_IDLE  | waiting for a plaintext block, key 0 presented
// ST_ROUND | applying round rnd (1..NR) to state_reg
// ST_DONE  | ciphertext held on out_block until out_ready
module aes_round_engine
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [0:BLOCK_W-1]  in_block,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [0:BLOCK_W-1]  rk,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [0:BLOCK_W-1]  out_block,
  output logic                busy
);

  localparam int NR = NR_OF(NK);
  localparam logic [RK_IDX_W-1:0] NR_L = RK_IDX_W'(NR);

  if (!nk_is_legal(NK)) begin : g_bad_nk
    $error("aes_round_engine: NK must be 4, 6 or 8");
  end

  aes_state_e          r_state;
  aes_state_e          w_next_state;
  logic [0:BLOCK_W-1]  r_data;
  logic [0:BLOCK_W-1]  w_data_next;
  logic [0:BLOCK_W-1]  w_round_out;
  logic [RK_IDX_W-1:0] r_rnd;
  logic [RK_IDX_W-1:0] w_rnd_next;
  logic                w_final;
  logic                w_accept;

  assign w_final   = (r_rnd == NR_L);
  assign out_block = r_data;

  aes_round_datapath u_round (
    .i_state (r_data),
    .i_key   (rk),
    .i_final (w_final),
    .o_state (w_round_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_rnd  <= '0;
    end else begin
      r_data <= w_data_next;
      r_rnd  <= w_rnd_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_data_next  = r_data;
    w_rnd_next   = r_rnd;
    w_accept     = 1'b0;
    in_ready     = 1'b0;
    rk_idx       = '0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        w_accept = in_valid;
      end
      ST_ROUND: begin
        busy        = 1'b1;
        rk_idx      = r_rnd;
        w_data_next = w_round_out;
        if (w_final) w_next_state = ST_DONE;
        else         w_rnd_next   = r_rnd + RK_IDX_W'(1);
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) w_accept     = 1'b1;
          else          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    // Acceptance is identical from IDLE and from DONE (back-to-back); rk is key 0 here.
    if (w_accept) begin
      w_data_next  = in_block ^ rk;
      w_rnd_next   = RK_IDX_W'(1);
      w_next_state = ST_ROUND;
    end
  end

endmodule

// File: doc/aes_round_engine.md
# aes_round_engine

Iterative AES encryption datapath that runs one full cipher round per clock, reusing a single round datapath for all rounds. Parametrised for AES-128/192/256 through the key-word count. Sits between the block-level input buffer and the ciphertext output stage. Requests each round key by index from an external key-schedule store, and moves blocks in and out with valid/ready handshakes.

## Interface
Parameters:
- NK, default 4, key length in 32-bit words; legal values 4, 6, 8. NR = NK + 6 (10/12/14 rounds). Any other value is a compile-time error.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  a plaintext block is offered.
- in_ready  out  1  the engine accepts a block on this cycle.
- in_block  in  128  plaintext, [0:127]; byte 0 at bits 0:7, column-major state order.
- rk_idx  out  4  index (0..NR) of the round key needed this cycle.
- rk  in  128  round key for rk_idx, combinational from the key store, valid in the same cycle.
- out_valid  out  1  a ciphertext block is held on out_block.
- out_ready  in  1  downstream takes the block.
- out_block  out  128  ciphertext, same byte order as in_block.
- busy  out  1  high in the ROUND state.

## Operation
- FSM states: IDLE, ROUND, DONE. Reset value is IDLE.
- IDLE
  - in_ready=1, rk_idx=0.
  - On in_valid: state_reg <= in_block ^ rk (initial AddRoundKey), rnd <= 1, go to ROUND.
- ROUND
  - rk_idx=rnd.
  - If rnd < NR: state_reg <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), rk), then rnd <= rnd+1.
  - If rnd == NR: the final round skips MixColumns. The result goes to state_reg, then go to DONE.
  - in_ready=0. in_valid is ignored.
- DONE
  - out_valid=1 and out_block=state_reg, held stable until out_ready.
  - rk_idx=0 and in_ready=out_ready.
  - out_ready & in_valid: accept the new block exactly as in IDLE and go to ROUND (back-to-back).
  - out_ready & !in_valid: go to IDLE.
- out_block is driven from state_reg at all times. It is only meaningful while out_valid=1.
- Key-store changes are the caller's responsibility. The engine samples rk every cycle and does not buffer keys.

## Timing
- Reset (async assert, released synchronously): state=IDLE, state_reg=0, rnd=0, out_valid=0, busy=0, in_ready=1, rk_idx=0.
- Reset mid-operation discards the block in flight. No partial output appears.
- Accept edge A0. Edges A1..A(NR) perform rounds 1..NR. out_valid rises after edge A(NR).
  - Latency is NR cycles from acceptance to out_valid: 10/12/14.
- Throughput:
  - With out_ready held high and in_valid continuous, one block every NR+1 cycles.
  - If out_ready is low, the engine stalls indefinitely in DONE and out_block stays constant.
- rnd is 4 bits and is never incremented past NR, so it does not wrap.
- in_ready is a combinational function of FSM state and out_ready. No other output depends combinationally on inputs.

## Structure
- Package aes_pkg:
  - NR_OF(nk) function.
  - FSM state enum.
  - BLOCK_W=128, RK_IDX_W=4.
  - Legal-NK check.
- One sub-module, aes_round_datapath: combinational.
  - Inputs: state, key, and final flag (bypasses MixColumns).
  - Built from the existing SubBytes, shift_rows, MixColumns and AddRoundKey blocks.
- The engine holds the FSM, rnd counter, state_reg and handshake logic.

## Test plan
- AES-128, FIPS-197 App. B.
  - Stimulus: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, bench model serves round keys by rk_idx.
  - Required: out_block=3925841d02dc09fbdc118597196a0b32, with out_valid 10 cycles after accept.
- AES-192 (NK=6) and AES-256 (NK=8), App. C.2/C.3.
  - Stimulus: pt 00112233445566778899aabbccddeeff.
  - Required: dda97ca4864cdfe06eaf70a0ec0d7191 at 12 cycles and 8ea2b7ca516745bfeafc49904b496089 at 14 cycles.
- Back-to-back.
  - Stimulus: two App. C.1 blocks with in_valid and out_ready held high.
  - Required: 69c4e0d86a7b0430d8cdb78070b4c55a twice; second accept occurs on the cycle the first is taken; out_valid pulses spaced 11 cycles.
- Output stall.
  - Stimulus: out_ready low for 20 cycles after completion.
  - Required: out_block constant, in_ready=0, rk_idx=0; block released on the first out_ready cycle.
- Reset mid-round.
  - Stimulus: assert rst at round 5.
  - Required: immediately state=IDLE, out_valid=0, in_ready=1; the next block encrypts correctly.
- in_valid during ROUND.
  - Stimulus: toggle in_valid while busy=1.
  - Required: no acceptance and result unchanged.
